execute_memory_register: RTL and testbench
==========================================

Name: execute_memory_register

Overview:
EX/MEM pipeline boundary directly downstream of the ALU in the MIPS32 core. Registers the ALU result, store data, destination register and control bits into the memory stage. Converts an ALU signed-overflow on a trapping instruction (ADD/ADDI/SUB) into a precise arithmetic-overflow exception request: it suppresses all side effects of the faulting instruction and squashes younger instructions until the exception is acknowledged.

Parameters:
EXC_CODE_OV, 5'd12, exception code reported for arithmetic overflow
COUNT_WIDTH, 16, width of the saturating overflow-trap counter

Ports:
clock  in  1  core clock; all state updates on rising edge
reset  in  1  synchronous, active-high
stall  in  1  memory stage stalled; hold all registered outputs
flush  in  1  insert a bubble into MEM this cycle
EX_ALUResult  in  32  ALU result
EX_Overflow  in  1  ALU overflow flag
EX_TrapOnOverflow  in  1  instruction traps on overflow (ADD/ADDI/SUB)
EX_Valid  in  1  EX holds a real instruction
EX_RegWrite  in  1  writes register file
EX_MemRead  in  1  load
EX_MemWrite  in  1  store
EX_StoreData  in  32  forwarded rt value
EX_DestReg  in  5  destination register
EX_PC  in  32  instruction PC
ExceptionAck  in  1  coprocessor 0 has taken the exception
M_ALUResult  out  32  registered result / memory address
M_StoreData  out  32  registered store data
M_DestReg  out  5  registered destination
M_PC  out  32  registered PC
M_Valid, M_RegWrite, M_MemRead, M_MemWrite  out  1 each  registered control
ExceptionPending  out  1  overflow exception awaiting acknowledgement
ExceptionPC  out  32  PC of faulting instruction
ExceptionCode  out  5  EXC_CODE_OV while pending, else 0
OverflowCount  out  COUNT_WIDTH  number of overflow traps taken, saturating

Behaviour:
- Reset: every output 0; state IDLE. Reset mid-pending clears ExceptionPending and squashing.
- Priority per edge: reset > flush > stall > capture.
- Capture, 1-cycle latency: all EX_* copy into M_* when not stalled and not flushed.
- Stall: all M_* and exception state hold. Overflow is not evaluated; the instruction stays in EX upstream. ExceptionAck is still honoured.
- Flush: M_Valid, M_RegWrite, M_MemRead, M_MemWrite become 0. Data fields are don't-care and are driven 0. Flush does not clear ExceptionPending.
- Bubble: EX_Valid=0 forces the M_ control bits to 0 on capture.
- Trap condition, evaluated only when capturing in IDLE: EX_Valid & EX_TrapOnOverflow & EX_Overflow.
  - Faulting instruction enters MEM as a bubble; rd is never written.
  - ExceptionPC=EX_PC; ExceptionCode=EXC_CODE_OV; ExceptionPending=1.
  - OverflowCount increments, holding at all-ones.
  - State goes to PENDING.
- Overflow with EX_TrapOnOverflow=0 (ADDU/SUBU/logic ops): ignored; captured normally.
- PENDING: every captured instruction is squashed to a bubble. ExceptionPC and ExceptionCode hold.
- PENDING exit: ExceptionAck=1 clears ExceptionPending and ExceptionCode and returns to IDLE on the next edge.
  - The instruction arriving in the ack cycle is still squashed.
  - A second overflow in that cycle is not trapped and not counted.
- ExceptionAck in IDLE: ignored.
- States: IDLE -(trap)-> PENDING -(ack)-> IDLE; reset -> IDLE from any state.

Test Plan:
- Reset then normal flow: ADD with result 0x00000007, dest 5, RegWrite=1 -> next cycle M_ALUResult=0x00000007, M_DestReg=5, M_RegWrite=1, M_Valid=1.
- Trapping overflow: A=0x7FFFFFFF+B=1, EX_Overflow=1, TrapOnOverflow=1, PC=0x00400010 -> M_RegWrite=0, M_Valid=0, ExceptionPending=1, ExceptionPC=0x00400010, ExceptionCode=12, OverflowCount=1.
- Squash and ack: while pending, feed SW at 0x00400014 -> M_MemWrite=0. Assert ExceptionAck -> pending=0 next cycle. Following LW is captured with M_MemRead=1.
- Non-trapping overflow: ADDU with EX_Overflow=1 -> result 0x80000000 captured, M_RegWrite=1, no exception.
- Stall hold: stall=1 for 3 cycles with changing EX inputs and EX_Overflow=1 -> M_* unchanged, no trap. Release stall -> trap taken once.
- Flush vs stall and reset mid-pending: flush=1 and stall=1 together -> bubble. Reset during PENDING -> all outputs 0, OverflowCount=0.

Source files
------------

// File: rtl/execute_memory_register.sv
// EX/MEM pipeline register for the MIPS32 core.
// Converts a trapping ALU overflow into a precise exception request and squashes younger instructions until it is acknowledged.
module execute_memory_register #(
  parameter logic [4:0] EXC_CODE_OV = 5'd12,
  parameter int         COUNT_WIDTH = 16
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   stall,
  input  logic                   flush,
  input  logic [31:0]            EX_ALUResult,
  input  logic                   EX_Overflow,
  input  logic                   EX_TrapOnOverflow,
  input  logic                   EX_Valid,
  input  logic                   EX_RegWrite,
  input  logic                   EX_MemRead,
  input  logic                   EX_MemWrite,
  input  logic [31:0]            EX_StoreData,
  input  logic [4:0]             EX_DestReg,
  input  logic [31:0]            EX_PC,
  input  logic                   ExceptionAck,
  output logic [31:0]            M_ALUResult,
  output logic [31:0]            M_StoreData,
  output logic [4:0]             M_DestReg,
  output logic [31:0]            M_PC,
  output logic                   M_Valid,
  output logic                   M_RegWrite,
  output logic                   M_MemRead,
  output logic                   M_MemWrite,
  output logic                   ExceptionPending,
  output logic [31:0]            ExceptionPC,
  output logic [4:0]             ExceptionCode,
  output logic [COUNT_WIDTH-1:0] OverflowCount
);

  typedef enum logic {
    IDLE,
    PENDING
  } state_t;

  state_t state, state_next;
  logic   capture;
  logic   trap;
  logic   squash;
  logic   keep;

  // NOTE: every signal assigned in an always_comb gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    state_next = state;
    capture    = !flush && !stall;
    trap       = 1'b0;
    squash     = 1'b0;
    keep       = 1'b0;

    if (capture && state == IDLE)
      trap = EX_Valid && EX_TrapOnOverflow && EX_Overflow;

    // Younger instructions are dropped for as long as the exception is outstanding, including the ack cycle.
    squash = trap || (state == PENDING);
    keep   = EX_Valid && !squash;

    if (trap)
      state_next = PENDING;
    else if (state == PENDING && ExceptionAck)
      state_next = IDLE;
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clock) begin
    if (reset)
      state <= IDLE;
    else
      state <= state_next;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      M_ALUResult <= '0;
      M_StoreData <= '0;
      M_DestReg   <= '0;
      M_PC        <= '0;
      M_Valid     <= 1'b0;
      M_RegWrite  <= 1'b0;
      M_MemRead   <= 1'b0;
      M_MemWrite  <= 1'b0;
    end else if (flush) begin
      M_ALUResult <= '0;
      M_StoreData <= '0;
      M_DestReg   <= '0;
      M_PC        <= '0;
      M_Valid     <= 1'b0;
      M_RegWrite  <= 1'b0;
      M_MemRead   <= 1'b0;
      M_MemWrite  <= 1'b0;
    end else if (!stall) begin
      M_ALUResult <= EX_ALUResult;
      M_StoreData <= EX_StoreData;
      M_DestReg   <= EX_DestReg;
      M_PC        <= EX_PC;
      M_Valid     <= keep;
      M_RegWrite  <= keep && EX_RegWrite;
      M_MemRead   <= keep && EX_MemRead;
      M_MemWrite  <= keep && EX_MemWrite;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      ExceptionPC   <= '0;
      OverflowCount <= '0;
    end else if (trap) begin
      ExceptionPC <= EX_PC;
      if (!(&OverflowCount))
        OverflowCount <= OverflowCount + COUNT_WIDTH'(1);
    end
  end

  assign ExceptionPending = (state == PENDING);
  assign ExceptionCode    = ExceptionPending ? EXC_CODE_OV : 5'd0;

endmodule

// File: tb/tb_execute_memory_register.sv
// Self-checking bench for execute_memory_register: directed scenarios plus random traffic,
// with a behavioural model feeding a scoreboard queue that a separate monitor drains.
module tb_execute_memory_register;

  localparam int CW = 4;  // narrow counter so saturation is reachable

  logic          clock, reset, stall, flush;
  logic [31:0]   EX_ALUResult, EX_StoreData, EX_PC;
  logic          EX_Overflow, EX_TrapOnOverflow, EX_Valid;
  logic          EX_RegWrite, EX_MemRead, EX_MemWrite;
  logic [4:0]    EX_DestReg;
  logic          ExceptionAck;
  logic [31:0]   M_ALUResult, M_StoreData, M_PC, ExceptionPC;
  logic [4:0]    M_DestReg, ExceptionCode;
  logic          M_Valid, M_RegWrite, M_MemRead, M_MemWrite, ExceptionPending;
  logic [CW-1:0] OverflowCount;

  execute_memory_register #(.EXC_CODE_OV(5'd12), .COUNT_WIDTH(CW)) dut (
    .clock(clock), .reset(reset), .stall(stall), .flush(flush),
    .EX_ALUResult(EX_ALUResult), .EX_Overflow(EX_Overflow),
    .EX_TrapOnOverflow(EX_TrapOnOverflow), .EX_Valid(EX_Valid),
    .EX_RegWrite(EX_RegWrite), .EX_MemRead(EX_MemRead), .EX_MemWrite(EX_MemWrite),
    .EX_StoreData(EX_StoreData), .EX_DestReg(EX_DestReg), .EX_PC(EX_PC),
    .ExceptionAck(ExceptionAck),
    .M_ALUResult(M_ALUResult), .M_StoreData(M_StoreData), .M_DestReg(M_DestReg),
    .M_PC(M_PC), .M_Valid(M_Valid), .M_RegWrite(M_RegWrite), .M_MemRead(M_MemRead),
    .M_MemWrite(M_MemWrite), .ExceptionPending(ExceptionPending),
    .ExceptionPC(ExceptionPC), .ExceptionCode(ExceptionCode), .OverflowCount(OverflowCount)
  );

  typedef struct {
    bit          rst, stl, fl, ov, trp, vld, rw, mr, mw, ack;
    logic [31:0] alu, sd, pc;
    logic [4:0]  dest;
  } stim_t;

  typedef struct {
    logic [31:0]   alu, sd, pc, epc;
    logic [4:0]    dest, ecode;
    bit            vld, rw, mr, mw, pend, cmp_data;
    logic [CW-1:0] cnt;
  } exp_t;

  exp_t exp_q[$];
  exp_t mdl;       // what MEM should show after the current edge
  int   checks   = 0;
  int   failures = 0;
  int   cyc      = 0;

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
    checks++;
    if (act !== want) begin
      failures++;
      $display("FAIL %s (cycle %0d): got %h expected %h", name, cyc, act, want);
    end
  endtask

  // Reference model: an exception is outstanding from a trap until an ack; outstanding
  // exceptions turn every captured instruction into a bubble.
  function automatic void model(input stim_t s);
    bit take;
    if (s.rst) begin
      mdl = '{alu: 0, sd: 0, pc: 0, epc: 0, dest: 0, ecode: 0, vld: 0, rw: 0, mr: 0,
              mw: 0, pend: 0, cmp_data: 1, cnt: 0};
      return;
    end
    take = 0;
    if (s.fl) begin
      mdl.alu = 0; mdl.sd = 0; mdl.pc = 0; mdl.dest = 0;
      mdl.vld = 0; mdl.rw = 0; mdl.mr = 0; mdl.mw = 0; mdl.cmp_data = 1;
    end else if (!s.stl) begin
      take = !mdl.pend && s.vld && s.trp && s.ov;
      mdl.alu = s.alu; mdl.sd = s.sd; mdl.pc = s.pc; mdl.dest = s.dest;
      if (take || mdl.pend) begin
        mdl.vld = 0; mdl.rw = 0; mdl.mr = 0; mdl.mw = 0;
        mdl.cmp_data = 0;  // contents of a squashed slot are not defined
      end else begin
        mdl.vld = s.vld; mdl.rw = s.vld && s.rw; mdl.mr = s.vld && s.mr; mdl.mw = s.vld && s.mw;
        mdl.cmp_data = 1;
      end
    end
    if (take) begin
      mdl.pend = 1;
      mdl.epc  = s.pc;
      if (mdl.cnt != {CW{1'b1}}) mdl.cnt = mdl.cnt + 1'b1;
    end else if (mdl.pend && s.ack) begin
      mdl.pend = 0;
    end
    mdl.ecode = mdl.pend ? 5'd12 : 5'd0;
  endfunction

  task automatic drive(input stim_t s);
    @(negedge clock);
    reset = s.rst; stall = s.stl; flush = s.fl;
    EX_ALUResult = s.alu; EX_Overflow = s.ov; EX_TrapOnOverflow = s.trp; EX_Valid = s.vld;
    EX_RegWrite = s.rw; EX_MemRead = s.mr; EX_MemWrite = s.mw; EX_StoreData = s.sd;
    EX_DestReg = s.dest; EX_PC = s.pc; ExceptionAck = s.ack;
    model(s);
    exp_q.push_back(mdl);
  endtask

  function automatic stim_t idle_stim();
    stim_t s;
    s = '{default: 0};
    return s;
  endfunction

  function automatic stim_t instr(input logic [31:0] pc, input logic [31:0] alu,
                                  input logic [4:0] dest, input bit rw, input bit mr, input bit mw);
    stim_t s;
    s = idle_stim();
    s.vld = 1; s.pc = pc; s.alu = alu; s.dest = dest; s.rw = rw; s.mr = mr; s.mw = mw;
    s.sd = pc ^ 32'hA5A5_0000;
    return s;
  endfunction

  // Monitor: MEM presents a new value after every edge; compare it against the oldest expectation.
  initial begin
    exp_t e;
    forever begin
      @(posedge clock);
      #1;
      cyc++;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("M_Valid", 32'(M_Valid), 32'(e.vld));
        check("M_RegWrite", 32'(M_RegWrite), 32'(e.rw));
        check("M_MemRead", 32'(M_MemRead), 32'(e.mr));
        check("M_MemWrite", 32'(M_MemWrite), 32'(e.mw));
        check("ExceptionPending", 32'(ExceptionPending), 32'(e.pend));
        check("ExceptionCode", 32'(ExceptionCode), 32'(e.ecode));
        check("ExceptionPC", ExceptionPC, e.epc);
        check("OverflowCount", 32'(OverflowCount), 32'(e.cnt));
        if (e.cmp_data) begin
          check("M_ALUResult", M_ALUResult, e.alu);
          check("M_StoreData", M_StoreData, e.sd);
          check("M_DestReg", 32'(M_DestReg), 32'(e.dest));
          check("M_PC", M_PC, e.pc);
        end
      end
    end
  end

  initial begin
    stim_t s;
    drive_defaults();
    mdl = '{default: 0};

    // Reset, then an ordinary ADD.
    s = idle_stim(); s.rst = 1;
    drive(s); drive(s);
    drive(instr(32'h0040_000C, 32'h0000_0007, 5'd5, 1, 0, 0));

    // Trapping overflow at 0x00400010, then a squashed SW, then the ack cycle (SW still squashed).
    s = instr(32'h0040_0010, 32'h8000_0000, 5'd6, 1, 0, 0); s.ov = 1; s.trp = 1;
    drive(s);
    drive(instr(32'h0040_0014, 32'h1000_0020, 5'd0, 0, 0, 1));
    s = instr(32'h0040_0014, 32'h1000_0020, 5'd0, 0, 0, 1); s.ack = 1;
    drive(s);
    drive(instr(32'h0040_0018, 32'h1000_0024, 5'd8, 1, 1, 0));

    // ADDU overflow is not a trap.
    s = instr(32'h0040_001C, 32'h8000_0000, 5'd9, 1, 0, 0); s.ov = 1;
    drive(s);

    // Three stalled cycles with changing overflowing inputs, then release: exactly one trap.
    for (int i = 0; i < 3; i++) begin
      s = instr(32'h0040_0020 + 32'(4 * i), 32'h8000_0000 + 32'(i), 5'd10, 1, 0, 0);
      s.ov = 1; s.trp = 1; s.stl = 1;
      drive(s);
    end
    s = instr(32'h0040_0030, 32'h8000_0003, 5'd10, 1, 0, 0); s.ov = 1; s.trp = 1;
    drive(s);

    // Second overflow arriving in the ack cycle is neither trapped nor counted.
    s = instr(32'h0040_0034, 32'h8000_0004, 5'd11, 1, 0, 0); s.ov = 1; s.trp = 1; s.ack = 1;
    drive(s);
    drive(instr(32'h0040_0038, 32'h0000_0042, 5'd12, 1, 0, 0));

    // Flush wins over stall; ack while idle is ignored.
    s = instr(32'h0040_003C, 32'hDEAD_BEEF, 5'd13, 1, 0, 1); s.fl = 1; s.stl = 1;
    drive(s);
    s = instr(32'h0040_0040, 32'h0000_0001, 5'd14, 1, 0, 0); s.ack = 1;
    drive(s);

    // Trap, flush while pending (pending survives), then reset mid-pending.
    s = instr(32'h0040_0044, 32'h8000_0000, 5'd15, 1, 0, 0); s.ov = 1; s.trp = 1;
    drive(s);
    s = idle_stim(); s.fl = 1;
    drive(s);
    s = instr(32'h0040_0048, 32'h0000_0005, 5'd16, 1, 0, 0); s.rst = 1;
    drive(s);
    drive(instr(32'h0040_004C, 32'h0000_0006, 5'd17, 1, 0, 0));

    // Random traffic; traps are frequent enough that the narrow counter saturates.
    for (int i = 0; i < 3000; i++) begin
      s.rst  = ($urandom_range(0, 399) == 0);
      s.fl   = ($urandom_range(0, 9) == 0);
      s.stl  = ($urandom_range(0, 4) == 0);
      s.vld  = ($urandom_range(0, 3) != 0);
      s.ov   = ($urandom_range(0, 3) == 0);
      s.trp  = $urandom_range(0, 1) == 1;
      s.rw   = $urandom_range(0, 1) == 1;
      s.mr   = $urandom_range(0, 1) == 1;
      s.mw   = $urandom_range(0, 1) == 1;
      s.ack  = !s.fl && ($urandom_range(0, 3) == 0);
      s.alu  = $urandom;
      s.sd   = $urandom;
      s.pc   = {$urandom_range(0, 32'h3FFF_FFFF), 2'b00};
      s.dest = 5'($urandom_range(0, 31));
      drive(s);
    end

    s = idle_stim();
    drive(s);
    repeat (3) @(posedge clock);
    #2;
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain: got %0d entries left expected 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  task automatic drive_defaults();
    reset = 1; stall = 0; flush = 0;
    EX_ALUResult = 0; EX_Overflow = 0; EX_TrapOnOverflow = 0; EX_Valid = 0;
    EX_RegWrite = 0; EX_MemRead = 0; EX_MemWrite = 0; EX_StoreData = 0;
    EX_DestReg = 0; EX_PC = 0; ExceptionAck = 0;
  endtask

endmodule
